i2c_slv_reg_bank: RTL
=====================

I2C_SLV_REG_BANK -- requirements
Module: i2c_slv_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 8-bit registers addressable, range 2..256.
REQ-002 SHALL have parameter PTR_W, default 4, register pointer width, with 2**PTR_W >= NUM_REGS.
REQ-003 SHALL have parameter NUM_CLKS_IDLE_TO, default 800, i_clk cycles of SCL-high inactivity before bus is declared idle.
REQ-004 SHALL have parameter NUM_CLKS_T_BUF, default 80, i_clk cycles after STOP before bus is declared idle.
REQ-005 SHALL have parameter WIDTH_IDLE_TO, default 10, idle timer width.
REQ-006 SHALL have port i_clk, input, 1, the single clock.
REQ-007 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_addr, input, 7, slave address.
REQ-009 SHALL have ports i_scl and i_sda, inputs, 1 each, bus lines.
REQ-010 SHALL have port o_sda, output, 1, open-drain SDA drive, 0 = pull low.
REQ-011 SHALL have ports o_wr_stb (1), o_wr_idx (PTR_W) and o_wr_data (8), outputs, user register write.
REQ-012 SHALL have port o_rd_idx, output, PTR_W, index of the register being read.
REQ-013 SHALL have port i_rd_data, input, 8, user register content at o_rd_idx.
REQ-014 SHALL have port o_busy, output, 1, high while the slave is addressed.

Function
REQ-015 SHALL detect START as an SDA fall while SCL is high, STOP as an SDA rise while SCL is high, sample SDA on SCL rise and change o_sda one i_clk after the detected SCL fall.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK and IGNORE.
REQ-017 SHALL go from any state to ADDR on START, including repeated START, and to IDLE on STOP or idle timeout.
REQ-018 SHALL ACK a matching address by driving 0 during the 9th bit; on R/W=0 SHALL go to PTR, on R/W=1 to RD; on mismatch SHALL release SDA and go to IGNORE.
REQ-019 SHALL ACK the first write byte and load it into the pointer if it is below NUM_REGS, otherwise SHALL NACK it, keep the pointer and go to IGNORE.
REQ-020 SHALL, for each later write byte, pulse o_wr_stb for exactly one i_clk in the cycle after the SCL fall ending bit 8, with o_wr_idx = pointer, then ACK the byte and increment the pointer.
REQ-021 SHALL, in RD, present the pointer on o_rd_idx, latch i_rd_data at the start of the byte, and shift it out MSB first.
REQ-022 SHALL, on master ACK in RD_ACK, increment the pointer and send the next byte; on master NACK SHALL release SDA and go to IGNORE.
REQ-023 SHALL wrap the pointer from NUM_REGS-1 to 0.
REQ-024 SHALL retain the pointer across repeated START, STOP and idle timeout, so that a write-pointer then repeated-START read reads from that pointer.
REQ-025 SHALL reload the idle timer with NUM_CLKS_IDLE_TO on START or SCL low, with NUM_CLKS_T_BUF on STOP, and otherwise decrement it to 0; timer 0 = idle.
REQ-026 SHALL never drive o_sda low in IDLE or IGNORE.
REQ-027 SHALL hold o_busy high in states ADDR_ACK through RD_ACK after an address match.

Reset
REQ-028 SHALL, while i_rstn is low, force state IDLE, o_sda=1, o_wr_stb=0, o_wr_idx=0, o_wr_data=0, o_rd_idx=0, pointer=0, o_busy=0 and idle timer=0.
REQ-029 SHALL, on reset assertion mid-transaction, release SDA immediately and ignore the bus until the next START.

Configuration
REQ-030 SHALL, with macro I2C_SLV_SYNC_EN defined, pass i_scl and i_sda through 2-FF synchronisers plus a 3-sample majority filter before edge detection, adding 4 i_clk cycles of latency to every bus event.
REQ-031 SHALL, with I2C_SLV_SYNC_EN undefined, use i_scl and i_sda directly, and be otherwise functionally identical.

Verification
REQ-032 SHALL cover: i_addr=0x42, write 0x84,0x03,0xAA,0xBB -> ACK all; strobes idx3=0xAA, idx4=0xBB; pointer=5.
REQ-033 SHALL cover: pointer=15, write 0x84,0x0F,0x11,0x22 -> writes idx15=0x11 then idx0=0x22, showing wrap.
REQ-034 SHALL cover: write 0x84,0x02, repeated START, 0x85, read 3 bytes with ACK,ACK,NACK -> o_rd_idx 2,3,4, data equals i_rd_data, SDA released after the NACK.
REQ-035 SHALL cover: address 0x43 with i_addr=0x42 -> no ACK, o_sda stays 1, no strobe.
REQ-036 SHALL cover: write 0x84,0x20 with NUM_REGS=16 -> pointer byte NACKed, pointer unchanged, further bytes ignored.
REQ-037 SHALL cover: i_rstn low mid-write byte -> o_sda=1 immediately, no strobe, next transaction is normal.

Source files
------------

// File: rtl/i2c_slv_reg_bank.sv
// I2C slave exposing a pointer-addressed bank of 8-bit user registers.
// Optional `I2C_SLV_SYNC_EN` adds 2-FF synchronisers and a 3-sample majority filter on SCL/SDA.
module i2c_slv_reg_bank #(
    parameter int unsigned NUM_REGS         = 16,
    parameter int unsigned PTR_W            = 4,
    parameter int unsigned NUM_CLKS_IDLE_TO = 800,
    parameter int unsigned NUM_CLKS_T_BUF   = 80,
    parameter int unsigned WIDTH_IDLE_TO    = 10
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [6:0]       i_addr,
    input  logic             i_scl,
    input  logic             i_sda,
    output logic             o_sda,
    output logic             o_wr_stb,
    output logic [PTR_W-1:0] o_wr_idx,
    output logic [7:0]       o_wr_data,
    output logic [PTR_W-1:0] o_rd_idx,
    input  logic [7:0]       i_rd_data,
    output logic             o_busy
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWr, StWrAck, StRd, StRdAck, StIgnore
    } state_e;

    logic scl_s, sda_s;

`ifdef I2C_SLV_SYNC_EN
    logic [1:0] scl_sync_q, sda_sync_q;
    logic [2:0] scl_hist_q, sda_hist_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= '1;
            sda_hist_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i_scl};
            sda_sync_q <= {sda_sync_q[0], i_sda};
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    assign scl_s = maj3(scl_hist_q);
    assign sda_s = maj3(sda_hist_q);
`else
    assign scl_s = i_scl;
    assign sda_s = i_sda;
`endif

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    state_e                   state_q, state_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               rx_q, rx_d;
    logic [7:0]               tx_q, tx_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic                     rw_q, rw_d;
    logic                     mack_q, mack_d;
    logic                     sda_out_q, sda_d;
    logic                     wr_stb_q, wr_stb_d;
    logic [PTR_W-1:0]         wr_idx_q, wr_idx_d;
    logic [7:0]               wr_data_q, wr_data_d;
    logic [WIDTH_IDLE_TO-1:0] timer_q, timer_d;
    logic                     scl_q, sda_q;

    logic scl_rise, scl_fall, start, stop;
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;

    always_comb begin
        timer_d = timer_q;
        if (start || !scl_s) begin
            timer_d = WIDTH_IDLE_TO'(NUM_CLKS_IDLE_TO);
        end else if (stop) begin
            timer_d = WIDTH_IDLE_TO'(NUM_CLKS_T_BUF);
        end else if (timer_q != '0) begin
            timer_d = timer_q - WIDTH_IDLE_TO'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        sda_d     = sda_out_q;
        wr_stb_d  = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (start) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
        end else if (stop || (state_q != StIdle && timer_q == '0)) begin
            state_d = StIdle;
            sda_d   = 1'b1;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWr: begin
                    if (scl_rise) begin
                        rx_d      = {rx_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == StAddr) begin
                            if (rx_q[7:1] == i_addr) begin
                                rw_d    = rx_q[0];
                                sda_d   = 1'b0;
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIgnore;
                            end
                        end else if (state_q == StPtr) begin
                            if (32'(rx_q) < NUM_REGS) begin
                                ptr_d   = PTR_W'(rx_q);
                                sda_d   = 1'b0;
                                state_d = StPtrAck;
                            end else begin
                                state_d = StIgnore;
                            end
                        end else begin
                            wr_stb_d  = 1'b1;
                            wr_idx_d  = ptr_q;
                            wr_data_d = rx_q;
                            ptr_d     = ptr_next(ptr_q);
                            sda_d     = 1'b0;
                            state_d   = StWrAck;
                        end
                    end
                end
                StAddrAck, StPtrAck, StWrAck: begin
                    if (scl_fall) begin
                        sda_d     = 1'b1;
                        bit_cnt_d = '0;
                        if (state_q == StAddrAck && rw_q) begin
                            // First read bit goes out on the same fall that ends the ACK
                            tx_d      = {i_rd_data[6:0], 1'b0};
                            sda_d     = i_rd_data[7];
                            bit_cnt_d = 4'd1;
                            state_d   = StRd;
                        end else if (state_q == StAddrAck) begin
                            state_d = StPtr;
                        end else begin
                            state_d = StWr;
                        end
                    end
                end
                StRd: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_d   = 1'b1;
                            state_d = StRdAck;
                        end else begin
                            sda_d     = tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRdAck: begin
                    // Advance on the ACK rise so i_rd_data tracks the new index by the fall
                    if (scl_rise) begin
                        mack_d = ~sda_s;
                        if (!sda_s) begin
                            ptr_d = ptr_next(ptr_q);
                        end
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            tx_d      = {i_rd_data[6:0], 1'b0};
                            sda_d     = i_rd_data[7];
                            bit_cnt_d = 4'd1;
                            state_d   = StRd;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = StIgnore;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
            sda_out_q <= 1'b1;
            wr_stb_q  <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            timer_q   <= '0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            sda_out_q <= sda_d;
            wr_stb_q  <= wr_stb_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            timer_q   <= timer_d;
            scl_q     <= scl_s;
            sda_q     <= sda_s;
        end
    end

    assign o_sda     = sda_out_q;
    assign o_wr_stb  = wr_stb_q;
    assign o_wr_idx  = wr_idx_q;
    assign o_wr_data = wr_data_q;
    assign o_rd_idx  = ptr_q;
    assign o_busy    = state_q inside {StAddrAck, StPtr, StPtrAck, StWr, StWrAck, StRd, StRdAck};

endmodule
